// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the regfile_sb register file.
package regfile_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int NBYTES     = DATA_W_DEF / 8;

    // Widest data path the shared helpers handle; narrower users extend to it.
    localparam int MAX_DATA_W = 128;
    localparam int MAX_BYTES  = MAX_DATA_W / 8;

    // Byte-merge: take byte k of new_v where strb[k]=1, otherwise keep old_v.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_v,
        input logic [MAX_DATA_W-1:0] new_v,
        input logic [MAX_BYTES-1:0]  strb
    );
        logic [MAX_DATA_W-1:0] r;
        r = old_v;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (strb[k]) begin
                r[8*k +: 8] = new_v[8*k +: 8];
            end
        end
        return r;
    endfunction

    // An address is mapped when it lies below depth and is not the
    // hardwired-zero register.
    function automatic logic addr_valid(
        input logic [31:0] a,
        input logic [31:0] depth,
        input logic        zero_reg
    );
        return (a < depth) && !(zero_reg && (a == 32'd0));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on reservation,
// cleared on writeback, with reservation taking priority on a collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] a1_i,
    input  logic [ADDR_W-1:0] a2_i,
    input  logic [ADDR_W-1:0] a3_i,
    input  logic [ADDR_W-1:0] rsv_a_i,
    input  logic              v1_i,
    input  logic              v2_i,
    input  logic              wr_v_i,
    input  logic              rsv_v_i,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic              any_busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             b1_raw;
    logic             b2_raw;

    // Next busy vector: clear on writeback first, then set on reservation so
    // that the newly issued instruction keeps ownership of the register.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_v_i && (a3_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (rsv_v_i && (rsv_a_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // Busy state register, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Look up the stored busy bit for each read address.
    always_comb begin
        b1_raw = 1'b0;
        b2_raw = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a1_i == ADDR_W'(i)) begin
                b1_raw = busy_q[i];
            end
            if (a2_i == ADDR_W'(i)) begin
                b2_raw = busy_q[i];
            end
        end
    end

    // A same-cycle writeback to the read address unblocks the reader only
    // when the data is being forwarded.
    always_comb begin
        busy1_o    = v1_i && b1_raw && !(BYPASS && wr_v_i && (a3_i == a1_i));
        busy2_o    = v2_i && b2_raw && !(BYPASS && wr_v_i && (a3_i == a2_i));
        any_busy_o = |busy_q;
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-byte write strobes, optional hardwired zero
// register, write-to-read bypass and a pending-write scoreboard.
// ADDR_W must not exceed 32 and DATA_W must not exceed MAX_DATA_W.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [ADDR_W-1:0]   A1,
    input  logic [ADDR_W-1:0]   A2,
    input  logic [ADDR_W-1:0]   A3,
    input  logic                WE3,
    input  logic [DATA_W/8-1:0] BE3,
    input  logic [DATA_W-1:0]   WD3,
    input  logic                RSV_EN,
    input  logic [ADDR_W-1:0]   RSV_A,
    output logic [DATA_W-1:0]   RD1,
    output logic [DATA_W-1:0]   RD2,
    output logic                BUSY1,
    output logic                BUSY2,
    output logic                ANY_BUSY
);

    logic [DATA_W-1:0] regs_q [DEPTH];

    logic              v1;
    logic              v2;
    logic              wr_v;
    logic              rsv_v;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_d;
    logic [DATA_W-1:0] rd1_raw;
    logic [DATA_W-1:0] rd2_raw;

    // Address qualification; everything is suppressed while reset is held so
    // that outputs read zero and no forwarded data leaks out during reset.
    always_comb begin
        v1    = !RST && addr_valid(32'(A1), 32'(DEPTH), ZERO_REG);
        v2    = !RST && addr_valid(32'(A2), 32'(DEPTH), ZERO_REG);
        wr_v  = !RST && WE3 && addr_valid(32'(A3), 32'(DEPTH), ZERO_REG);
        rsv_v = !RST && RSV_EN && addr_valid(32'(RSV_A), 32'(DEPTH), ZERO_REG);
    end

    // Storage read muxes for both read ports and the write-merge source.
    always_comb begin
        rd1_raw = '0;
        rd2_raw = '0;
        wr_old  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (A1 == ADDR_W'(i)) begin
                rd1_raw = regs_q[i];
            end
            if (A2 == ADDR_W'(i)) begin
                rd2_raw = regs_q[i];
            end
            if (A3 == ADDR_W'(i)) begin
                wr_old = regs_q[i];
            end
        end
    end

    // Merged write value: old contents overlaid with strobed bytes of WD3.
    always_comb begin
        wr_d = DATA_W'(byte_merge(MAX_DATA_W'(wr_old), MAX_DATA_W'(WD3),
                                  MAX_BYTES'(BE3)));
    end

    // Register array update; register 0 stays zero because wr_v excludes it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_v) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (A3 == ADDR_W'(i)) begin
                    regs_q[i] <= wr_d;
                end
            end
        end
    end

    // Read outputs; the merged write value is forwarded when the write hits
    // the read address (wr_old then equals the stored read value).
    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (v1) begin
            RD1 = (BYPASS && wr_v && (A3 == A1)) ? wr_d : rd1_raw;
        end
        if (v2) begin
            RD2 = (BYPASS && wr_v && (A3 == A2)) ? wr_d : rd2_raw;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk_i      (CLK),
        .rst_i      (RST),
        .a1_i       (A1),
        .a2_i       (A2),
        .a3_i       (A3),
        .rsv_a_i    (RSV_A),
        .v1_i       (v1),
        .v2_i       (v2),
        .wr_v_i     (wr_v),
        .rsv_v_i    (rsv_v),
        .busy1_o    (BUSY1),
        .busy2_o    (BUSY2),
        .any_busy_o (ANY_BUSY)
    );

endmodule
